// File: rtl/audio_out_pkg.sv
// audio_out_pkg: shared counter widths and slot pad/truncate helper for audio_out
package audio_out_pkg;

    // Width of a counter that must hold 0..n-1 (never below one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Right-aligned sample of in_bits placed into a right-aligned slot of slot_bits:
    // LSBs zero-padded when the slot is wider, LSBs dropped when it is narrower.
    function automatic logic [63:0] slot_fit(input logic [63:0] sample, input int in_bits, input int slot_bits);
        return (slot_bits >= in_bits) ? sample << (slot_bits - in_bits) : sample >> (in_bits - slot_bits);
    endfunction

endpackage

// File: rtl/sigma_delta_dac.sv
// sigma_delta_dac: first-order sigma-delta modulator for one audio channel
//   clk_sys  system clock
//   reset    asynchronous, active-high
//   din      PCM sample (two's complement when SIGNED, else offset binary)
//   dout     1-bit density output (carry of the accumulator)
module sigma_delta_dac #(
    parameter int IN_BITS = 16,
    parameter bit SIGNED  = 1
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [IN_BITS-1:0] din,
    output logic               dout
);

    logic [IN_BITS:0]   acc;
    logic [IN_BITS-1:0] u;

    // Flipping the MSB maps two's complement onto offset binary.
    assign u    = din ^ (IN_BITS'(SIGNED) << (IN_BITS - 1));
    assign dout = acc[IN_BITS];

    always_ff @(posedge clk_sys or posedge reset)
        if (reset)
            acc <= '0;
        else
            acc <= {1'b0, acc[IN_BITS-1:0]} + {1'b0, u};

endmodule

// File: rtl/audio_out.sv
// audio_out: stereo sample handshake, Philips I2S serialiser and sigma-delta DAC pins
//   clk_sys, reset          sole clock, asynchronous active-high reset
//   sample_l/r, sample_valid, sample_ready   one-entry holding register handshake
//   i2s_bck, i2s_lrck, i2s_data              I2S bit clock, word select (0 = left), data MSB first
//   dac_l, dac_r            sigma-delta outputs driven from the current frame
//   underrun                one-cycle pulse when a frame starts with the holding register empty
module audio_out
    import audio_out_pkg::*;
#(
    parameter int IN_BITS   = 16,
    parameter int SLOT_BITS = 16,
    parameter int BCK_DIV   = 8,
    parameter bit SIGNED    = 1
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [IN_BITS-1:0] sample_l,
    input  logic [IN_BITS-1:0] sample_r,
    input  logic               sample_valid,
    output logic               sample_ready,
    output logic               i2s_bck,
    output logic               i2s_lrck,
    output logic               i2s_data,
    output logic               dac_l,
    output logic               dac_r,
    output logic               underrun
);

    localparam int DW = cnt_w(BCK_DIV);
    localparam int FW = 2 * SLOT_BITS;
    localparam int BW = cnt_w(FW);

    logic [DW-1:0]      div;
    logic [BW-1:0]      bitcnt, nxt_cnt, idx;
    logic [IN_BITS-1:0] hold_l, hold_r, frame_l, frame_r;
    logic [FW-1:0]      stream;
    logic               full, bck_tc, fall, wrap, take;

    assign sample_ready = !full;

    always_comb begin
        bck_tc  = div == DW'(BCK_DIV - 1);
        fall    = bck_tc && i2s_bck;
        wrap    = fall && bitcnt == BW'(FW - 1);
        take    = sample_valid && !full;
        nxt_cnt = wrap ? '0 : bitcnt + BW'(1);
        stream  = {SLOT_BITS'(slot_fit(64'(frame_l), IN_BITS, SLOT_BITS)),
                   SLOT_BITS'(slot_fit(64'(frame_r), IN_BITS, SLOT_BITS))};
        // Data lags word select by one BCK: count n shows stream bit 2*SLOT_BITS-n,
        // and n=0 still shows the outgoing frame's right LSB (frame_r loads on this same edge).
        idx     = (nxt_cnt == '0) ? '0 : BW'(FW - 1) - nxt_cnt + BW'(1);
    end

    always_ff @(posedge clk_sys or posedge reset)
        if (reset) begin
            div      <= '0;
            i2s_bck  <= 1'b0;
            bitcnt   <= '0;
            i2s_lrck <= 1'b0;
            i2s_data <= 1'b0;
            underrun <= 1'b0;
            full     <= 1'b0;
            hold_l   <= '0;
            hold_r   <= '0;
            frame_l  <= '0;
            frame_r  <= '0;
        end else begin
            div      <= bck_tc ? '0 : div + DW'(1);
            i2s_bck  <= bck_tc ? ~i2s_bck : i2s_bck;
            underrun <= wrap && !full;
            full     <= take || (full && !wrap);
            if (fall) begin
                bitcnt   <= nxt_cnt;
                i2s_lrck <= nxt_cnt >= BW'(SLOT_BITS);
                i2s_data <= stream[idx];
            end
            if (wrap && full) begin
                frame_l <= hold_l;
                frame_r <= hold_r;
            end
            if (take) begin
                hold_l <= sample_l;
                hold_r <= sample_r;
            end
        end

    sigma_delta_dac #(.IN_BITS(IN_BITS), .SIGNED(SIGNED)) u_dac_l (
        .clk_sys (clk_sys),
        .reset   (reset),
        .din     (frame_l),
        .dout    (dac_l)
    );

    sigma_delta_dac #(.IN_BITS(IN_BITS), .SIGNED(SIGNED)) u_dac_r (
        .clk_sys (clk_sys),
        .reset   (reset),
        .din     (frame_r),
        .dout    (dac_r)
    );

endmodule

// File: tb/tb_audio_out.sv
// tb_audio_out: directed self-checking bench for audio_out (I2S framing, handshake, DAC, reset)
module tb_audio_out;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sample_l = '0, sample_r = '0, alt_l = '0, alt_r = '0;
    logic        sample_valid = 1'b0, alt_valid = 1'b0;

    logic m_ready, m_bck, m_lrck, m_data, m_dac_l, m_dac_r, m_underrun;
    logic a24_ready, a24_bck, a24_lrck, a24_data, a24_dac_l, a24_dac_r, a24_underrun;
    logic a8_ready, a8_bck, a8_lrck, a8_data, a8_dac_l, a8_dac_r, a8_underrun;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    audio_out #(.IN_BITS(16), .SLOT_BITS(16), .BCK_DIV(2), .SIGNED(1)) dut (
        .clk_sys(clk), .reset(reset), .sample_l(sample_l), .sample_r(sample_r),
        .sample_valid(sample_valid), .sample_ready(m_ready), .i2s_bck(m_bck),
        .i2s_lrck(m_lrck), .i2s_data(m_data), .dac_l(m_dac_l), .dac_r(m_dac_r),
        .underrun(m_underrun)
    );

    audio_out #(.IN_BITS(16), .SLOT_BITS(24), .BCK_DIV(2), .SIGNED(1)) dut24 (
        .clk_sys(clk), .reset(reset), .sample_l(alt_l), .sample_r(alt_r),
        .sample_valid(alt_valid), .sample_ready(a24_ready), .i2s_bck(a24_bck),
        .i2s_lrck(a24_lrck), .i2s_data(a24_data), .dac_l(a24_dac_l), .dac_r(a24_dac_r),
        .underrun(a24_underrun)
    );

    audio_out #(.IN_BITS(16), .SLOT_BITS(8), .BCK_DIV(2), .SIGNED(1)) dut8 (
        .clk_sys(clk), .reset(reset), .sample_l(alt_l), .sample_r(alt_r),
        .sample_valid(alt_valid), .sample_ready(a8_ready), .i2s_bck(a8_bck),
        .i2s_lrck(a8_lrck), .i2s_data(a8_data), .dac_l(a8_dac_l), .dac_r(a8_dac_r),
        .underrun(a8_underrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Main-DUT frame capture: a word is complete on the BCK rise where lrck has just toggled.
    logic [31:0] m_sr = '0;
    logic [15:0] m_left = '0, m_right = '0;
    logic        m_prev = 1'b0;
    int          m_lcap = 0, m_rcap = 0, m_run = 0, m_lo_run = 0, m_hi_run = 0;

    always @(posedge m_bck or posedge reset)
        if (reset) begin
            m_prev <= 1'b0;
            m_run  <= 0;
        end else begin
            m_sr   <= {m_sr[30:0], m_data};
            m_prev <= m_lrck;
            if (m_lrck != m_prev) begin
                m_run <= 1;
                if (m_lrck) begin
                    m_left   <= {m_sr[14:0], m_data};
                    m_lo_run <= m_run;
                    m_lcap   <= m_lcap + 1;
                end else begin
                    m_right  <= {m_sr[14:0], m_data};
                    m_hi_run <= m_run;
                    m_rcap   <= m_rcap + 1;
                end
            end else
                m_run <= m_run + 1;
        end

    logic [23:0] a24_sr = '0, a24_left = '0;
    logic        a24_prev = 1'b0;
    int          a24_lcap = 0;

    always @(posedge a24_bck) begin
        a24_prev <= a24_lrck;
        a24_sr   <= {a24_sr[22:0], a24_data};
        if (a24_lrck && !a24_prev) begin
            a24_left <= {a24_sr[22:0], a24_data};
            a24_lcap <= a24_lcap + 1;
        end
    end

    logic [7:0] a8_sr = '0, a8_left = '0;
    logic       a8_prev = 1'b0;
    int         a8_lcap = 0;

    always @(posedge a8_bck) begin
        a8_prev <= a8_lrck;
        a8_sr   <= {a8_sr[6:0], a8_data};
        if (a8_lrck && !a8_prev) begin
            a8_left <= {a8_sr[6:0], a8_data};
            a8_lcap <= a8_lcap + 1;
        end
    end

    int urun = 0;
    always @(negedge clk) if (m_underrun) urun <= urun + 1;

    task automatic write_pair(input logic [15:0] l, input logic [15:0] r, output int stall);
        stall        = 0;
        sample_l     = l;
        sample_r     = r;
        sample_valid = 1'b1;
        while (!m_ready && stall < 1000) begin
            @(negedge clk);
            stall++;
        end
        check("write_ready", 32'(m_ready), 1);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_rcap(input int n);
        int t = 0;
        while (m_rcap < n && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("wait_frame", 32'(m_rcap >= n), 1);
    endtask

    task automatic measure(output int lo, output int ro, output int alt_err);
        logic p;
        p       = m_dac_l;
        lo      = 0;
        ro      = 0;
        alt_err = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            lo += int'(m_dac_l);
            ro += int'(m_dac_r);
            if (m_dac_l == p) alt_err++;
            p = m_dac_l;
        end
    endtask

    initial begin
        int st, w, lo, ro, ae, n, t;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(m_ready), 1);
        check("rst_underrun", 32'(m_underrun), 0);
        check("rst_bck", 32'(m_bck), 0);
        check("rst_lrck", 32'(m_lrck), 0);
        check("rst_data", 32'(m_data), 0);
        check("rst_dac", 32'({m_dac_l, m_dac_r}), 0);
        reset = 1'b0;
        @(negedge clk);
        alt_l     = 16'hA5A5;
        alt_r     = 16'h0F0F;
        alt_valid = 1'b1;
        @(negedge clk);
        alt_valid = 1'b0;

        write_pair(16'h8001, 16'h7FFE, st);
        check("ready_low_full", 32'(m_ready), 0);
        wait_rcap(2);
        check("f1_left", 32'(m_left), 32'h8001);
        check("f1_right", 32'(m_right), 32'h7FFE);
        check("lrck_low_bcks", 32'(m_lo_run), 16);
        check("lrck_high_bcks", 32'(m_hi_run), 16);
        check("ready_after_load", 32'(m_ready), 1);
        check("underrun_cnt1", 32'(urun), 1);
        wait_rcap(3);
        check("f2_left_repeat", 32'(m_left), 32'h8001);
        check("f2_right_repeat", 32'(m_right), 32'h7FFE);
        check("underrun_cnt2", 32'(urun), 2);

        write_pair(16'h1234, 16'h5678, st);
        check("b2b_ready_low", 32'(m_ready), 0);
        write_pair(16'h9ABC, 16'hDEF0, st);
        check("b2b_stalled", 32'(st > 100), 1);
        check("b2b_ready_low2", 32'(m_ready), 0);
        wait_rcap(5);
        check("b2b_f1_left", 32'(m_left), 32'h1234);
        check("b2b_f1_right", 32'(m_right), 32'h5678);
        check("b2b_no_underrun", 32'(urun), 2);
        wait_rcap(6);
        check("b2b_f2_left", 32'(m_left), 32'h9ABC);
        check("b2b_f2_right", 32'(m_right), 32'hDEF0);
        check("underrun_cnt3", 32'(urun), 3);

        t = 0;
        while ((a24_lcap < 2 || a8_lcap < 2) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("slot24_left", 32'(a24_left), 32'hA5A500);
        check("slot8_left", 32'(a8_left), 32'hA5);

        write_pair(16'h0000, 16'h8000, st);
        w = m_rcap;
        wait_rcap(w + 2);
        measure(lo, ro, ae);
        check("sd_zero_ones", 32'(lo), 500);
        check("sd_zero_alternates", 32'(ae), 0);
        check("sd_min_ones", 32'(ro), 0);
        write_pair(16'h7FFF, 16'h0000, st);
        w = m_rcap;
        wait_rcap(w + 2);
        measure(lo, ro, ae);
        check("sd_max_density", 32'(lo >= 999), 1);
        check("sd_zero_ones_r", 32'(ro), 500);

        write_pair(16'h1111, 16'h2222, st);
        w = m_rcap;
        wait_rcap(w + 1);
        write_pair(16'h3333, 16'h4444, st);
        check("pre_rst_full", 32'(m_ready), 0);
        repeat (9) @(posedge m_bck);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 32'(m_ready), 1);
        check("mid_rst_outs", 32'({m_bck, m_lrck, m_data, m_underrun}), 0);
        check("mid_rst_dac", 32'({m_dac_l, m_dac_r}), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("post_rst_ready", 32'(m_ready), 1);
        n = 0;
        while (!m_underrun && n < 1000) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("post_rst_first_wrap", 32'(n), 128);
        @(negedge clk);
        check("underrun_one_cycle", 32'(m_underrun), 0);
        w = m_rcap;
        wait_rcap(w + 1);
        check("post_rst_left_zero", 32'(m_left), 0);
        check("post_rst_right_zero", 32'(m_right), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
